id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- Decode-to-execute pipeline stage of the pipelined RISC-V core, directly downstream of the register file.
- Captures the register-file read data (RD1/RD2) together with the decoded fields into the ID/EX pipeline register.
- Applies write-back bypass, because register-file reads return the pre-write value in the same cycle.
- Detects load-use hazards, inserts bubbles, honours flush and downstream hold, and counts inserted bubbles.

Parameters:
ADDR_WIDTH, 5, register index width
DATA_WIDTH, 32, operand/PC/immediate width
CNT_WIDTH, 16, bubble counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-low
id_valid  in  1  ID slot holds a real instruction
id_pc  in  DATA_WIDTH  instruction PC
id_rs1, id_rs2, id_rd  in  ADDR_WIDTH  source/dest indices (rs1/rs2 also drive register-file A1/A2)
id_use_rs1, id_use_rs2  in  1  instruction actually reads rs1/rs2
id_imm  in  DATA_WIDTH  decoded immediate
id_reg_write, id_mem_read, id_mem_write, id_alu_src  in  1  control bits
id_alu_op  in  4  ALU operation
rd1, rd2  in  DATA_WIDTH  register-file RD1/RD2
wb_we  in  1  write-back enable (same signal as register-file WE3)
wb_rd  in  ADDR_WIDTH  write-back index (A3)
wb_data  in  DATA_WIDTH  write-back data (WD3)
flush  in  1  taken branch/jump resolved in EX; squash ID
ex_hold  in  1  downstream stall; EX must keep its contents
stall_o  out  1  hold PC and IF/ID this cycle
ex_valid  out  1  EX slot valid
ex_pc, ex_imm, ex_op1, ex_op2  out  DATA_WIDTH  registered fields/operands
ex_rs1, ex_rs2, ex_rd  out  ADDR_WIDTH  registered indices (for EX forwarding)
ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src  out  1  registered controls
ex_alu_op  out  4  registered ALU op
bubble_cnt  out  CNT_WIDTH  saturating load-use bubble count

Behaviour:
- Reset (rst=0 at a clk edge): every registered output is 0, including ex_valid and bubble_cnt. Reset has priority over every other input.
- Operand select (combinational, per source):
  - If id_rsX==0: operand 0.
  - Else if wb_we & wb_rd!=0 & wb_rd==id_rsX: operand is wb_data.
  - Else: operand is rd1/rd2.
- hazard = id_valid & ex_valid & ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- stall_o = ex_hold | (hazard & ~flush). It is combinational, with no registered latency.
- Per-edge update, priority order:
  1. ex_hold=1: all ex_* and bubble_cnt keep their values. flush is ignored this cycle; the EX source keeps flush asserted until it is accepted.
  2. flush=1: all ex_* are cleared to 0 (bubble). No count.
  3. hazard=1: all ex_* are cleared to 0 (bubble). bubble_cnt increments, saturating at all-ones with no wrap.
  4. Otherwise: load id_* fields, the selected operands, and ex_valid<=id_valid. If id_valid=0, the controls load as 0 regardless of the id_* control inputs.
- Latency:
  - ID to EX is one cycle.
  - A load-use pair costs exactly one bubble: on the next cycle the load has left EX, so hazard clears.
- A hold during a pending hazard still asserts stall_o, and the hazard is re-evaluated once the hold drops.
- If flush and hazard occur together, flush wins: there is no bubble count, and stall_o reflects only ex_hold.
- Reset asserted mid-stall clears EX and bubble_cnt. stall_o then falls, because ex_valid=0.

Test Plan:
- Reset: hold rst=0 for 2 cycles with random inputs -> all outputs 0; release -> first valid ID (pc=0x100, imm=0x10) appears on ex_* one cycle later.
- WB bypass: rd1=0x1111, wb_we=1, wb_rd=5, wb_data=0xCAFE, id_rs1=5 -> ex_op1=0xCAFE. With wb_rd=0 -> ex_op1=0x1111. With id_rs1=0 -> ex_op1=0.
- Load-use: lw x6 in EX (ex_mem_read=1, ex_rd=6), ID add uses rs2=6 -> stall_o=1 for exactly one cycle, ex_valid=0 next cycle, bubble_cnt 0->1; add enters EX the following cycle. With id_use_rs2=0 -> no stall.
- Flush vs hazard: same setup plus flush=1 -> stall_o=0, ex_valid=0, bubble_cnt unchanged.
- Hold: ex_hold=1 for 3 cycles with changing id_* and flush=1 -> ex_* frozen, stall_o=1 throughout; flush is applied on the first cycle after the hold drops.
- Saturation: force 0xFFFF+2 hazard bubbles -> bubble_cnt stays at 0xFFFF.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-back bypass, load-use bubble insertion,
// flush/hold handling and a saturating count of inserted load-use bubbles.
module id_ex_stage #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [DATA_WIDTH-1:0] id_pc,
    input  logic [ADDR_WIDTH-1:0] id_rs1,
    input  logic [ADDR_WIDTH-1:0] id_rs2,
    input  logic [ADDR_WIDTH-1:0] id_rd,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [DATA_WIDTH-1:0] id_imm,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_alu_src,
    input  logic [3:0]            id_alu_op,
    input  logic [DATA_WIDTH-1:0] rd1,
    input  logic [DATA_WIDTH-1:0] rd2,
    input  logic                  wb_we,
    input  logic [ADDR_WIDTH-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  flush,
    input  logic                  ex_hold,
    output logic                  stall_o,
    output logic                  ex_valid,
    output logic [DATA_WIDTH-1:0] ex_pc,
    output logic [DATA_WIDTH-1:0] ex_imm,
    output logic [DATA_WIDTH-1:0] ex_op1,
    output logic [DATA_WIDTH-1:0] ex_op2,
    output logic [ADDR_WIDTH-1:0] ex_rs1,
    output logic [ADDR_WIDTH-1:0] ex_rs2,
    output logic [ADDR_WIDTH-1:0] ex_rd,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_alu_src,
    output logic [3:0]            ex_alu_op,
    output logic [CNT_WIDTH-1:0]  bubble_cnt
);

    localparam logic [ADDR_WIDTH-1:0] REG_ZERO  = {ADDR_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // The register file returns the pre-write value, so a same-cycle write-back wins.
    function automatic logic [DATA_WIDTH-1:0] select_operand(
        input logic [ADDR_WIDTH-1:0] rs,
        input logic [DATA_WIDTH-1:0] rf_data,
        input logic                  we,
        input logic [ADDR_WIDTH-1:0] wrd,
        input logic [DATA_WIDTH-1:0] wdata
    );
        logic [DATA_WIDTH-1:0] result;
        if (rs == REG_ZERO) begin
            result = DATA_ZERO;
        end else if (we && (wrd != REG_ZERO) && (wrd == rs)) begin
            result = wdata;
        end else begin
            result = rf_data;
        end
        return result;
    endfunction

    logic                  ex_valid_r;
    logic [DATA_WIDTH-1:0] ex_pc_r;
    logic [DATA_WIDTH-1:0] ex_imm_r;
    logic [DATA_WIDTH-1:0] ex_op1_r;
    logic [DATA_WIDTH-1:0] ex_op2_r;
    logic [ADDR_WIDTH-1:0] ex_rs1_r;
    logic [ADDR_WIDTH-1:0] ex_rs2_r;
    logic [ADDR_WIDTH-1:0] ex_rd_r;
    logic                  ex_reg_write_r;
    logic                  ex_mem_read_r;
    logic                  ex_mem_write_r;
    logic                  ex_alu_src_r;
    logic [3:0]            ex_alu_op_r;
    logic [CNT_WIDTH-1:0]  bubble_cnt_r;

    logic [DATA_WIDTH-1:0] op1_s;
    logic [DATA_WIDTH-1:0] op2_s;
    logic                  hazard_s;
    logic                  stall_s;
    logic                  bubble_s;
    logic                  cnt_inc_s;

    // Operand selection, load-use detection and stall request.
    always_comb begin
        op1_s     = select_operand(id_rs1, rd1, wb_we, wb_rd, wb_data);
        op2_s     = select_operand(id_rs2, rd2, wb_we, wb_rd, wb_data);
        hazard_s  = 1'b0;
        bubble_s  = 1'b0;
        cnt_inc_s = 1'b0;
        if (id_valid && ex_valid_r && ex_mem_read_r && (ex_rd_r != REG_ZERO)) begin
            hazard_s = (id_use_rs1 && (id_rs1 == ex_rd_r)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd_r));
        end else begin
            hazard_s = 1'b0;
        end
        // Flush outranks the hazard: the dependent instruction is squashed anyway.
        if (flush) begin
            bubble_s = 1'b1;
        end else if (hazard_s) begin
            bubble_s  = 1'b1;
            cnt_inc_s = (bubble_cnt_r != CNT_MAX);
        end else begin
            bubble_s = 1'b0;
        end
        stall_s = ex_hold || (hazard_s && !flush);
    end

    // ID/EX register and bubble counter; hold freezes everything, including flush.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_valid_r     <= 1'b0;
            ex_pc_r        <= DATA_ZERO;
            ex_imm_r       <= DATA_ZERO;
            ex_op1_r       <= DATA_ZERO;
            ex_op2_r       <= DATA_ZERO;
            ex_rs1_r       <= REG_ZERO;
            ex_rs2_r       <= REG_ZERO;
            ex_rd_r        <= REG_ZERO;
            ex_reg_write_r <= 1'b0;
            ex_mem_read_r  <= 1'b0;
            ex_mem_write_r <= 1'b0;
            ex_alu_src_r   <= 1'b0;
            ex_alu_op_r    <= 4'd0;
            bubble_cnt_r   <= {CNT_WIDTH{1'b0}};
        end else if (!ex_hold) begin
            if (bubble_s) begin
                ex_valid_r     <= 1'b0;
                ex_pc_r        <= DATA_ZERO;
                ex_imm_r       <= DATA_ZERO;
                ex_op1_r       <= DATA_ZERO;
                ex_op2_r       <= DATA_ZERO;
                ex_rs1_r       <= REG_ZERO;
                ex_rs2_r       <= REG_ZERO;
                ex_rd_r        <= REG_ZERO;
                ex_reg_write_r <= 1'b0;
                ex_mem_read_r  <= 1'b0;
                ex_mem_write_r <= 1'b0;
                ex_alu_src_r   <= 1'b0;
                ex_alu_op_r    <= 4'd0;
            end else begin
                ex_valid_r     <= id_valid;
                ex_pc_r        <= id_pc;
                ex_imm_r       <= id_imm;
                ex_op1_r       <= op1_s;
                ex_op2_r       <= op2_s;
                ex_rs1_r       <= id_rs1;
                ex_rs2_r       <= id_rs2;
                ex_rd_r        <= id_rd;
                ex_reg_write_r <= id_valid & id_reg_write;
                ex_mem_read_r  <= id_valid & id_mem_read;
                ex_mem_write_r <= id_valid & id_mem_write;
                ex_alu_src_r   <= id_valid & id_alu_src;
                ex_alu_op_r    <= id_valid ? id_alu_op : 4'd0;
            end
            if (cnt_inc_s) begin
                bubble_cnt_r <= bubble_cnt_r + CNT_ONE;
            end
        end
    end

    assign stall_o      = stall_s;
    assign ex_valid     = ex_valid_r;
    assign ex_pc        = ex_pc_r;
    assign ex_imm       = ex_imm_r;
    assign ex_op1       = ex_op1_r;
    assign ex_op2       = ex_op2_r;
    assign ex_rs1       = ex_rs1_r;
    assign ex_rs2       = ex_rs2_r;
    assign ex_rd        = ex_rd_r;
    assign ex_reg_write = ex_reg_write_r;
    assign ex_mem_read  = ex_mem_read_r;
    assign ex_mem_write = ex_mem_write_r;
    assign ex_alu_src   = ex_alu_src_r;
    assign ex_alu_op    = ex_alu_op_r;
    assign bubble_cnt   = bubble_cnt_r;

endmodule
